// File: rtl/zmips_pkg.sv
// Shared zmips constants and writeback source encoding.
package zmips_pkg;

  localparam int ZMIPS_NUM_GPR    = 30;
  localparam int ZMIPS_REG_PC     = 30;
  localparam int ZMIPS_REG_PCNEXT = 31;

  typedef enum logic {
    ALU = 1'b0,
    MEM = 1'b1
  } wb_src_t;

endpackage

// File: rtl/zmips_rr_arb2.sv
// Two-requester round-robin arbiter. Requester 0 maps to ALU and requester 1
// maps to MEM in the last-winner pointer. Grants are purely combinational
// from the requests and the pointer, and a grant is an accepted transfer.
module zmips_rr_arb2
  import zmips_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  wb_src_t last_q;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    gnt0 = req0 && (!req1 || (last_q == MEM));
    gnt1 = req1 && (!req0 || (last_q == ALU));
  end

  // The pointer follows the winner. The reset value lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= MEM;
    end else if (gnt0) begin
      last_q <= ALU;
    end else if (gnt1) begin
      last_q <= MEM;
    end
  end

endmodule

// File: rtl/zmips_rf_wr_arbiter.sv
// Register-file write-port arbiter with a load-destination scoreboard.
// The ALU and load writeback share one registered regfile write port.
// Writes to the PC aliases (addr >= NUM_GPR) complete the handshake and are
// then dropped. The scoreboard and the sticky WAW error exist only when
// ZMIPS_RF_SCOREBOARD_EN is defined. Otherwise they are tied off.
module zmips_rf_wr_arbiter
  import zmips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_GPR = ZMIPS_NUM_GPR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [ADDR_W-1:0]  alu_addr,
  input  logic [DATA_W-1:0]  alu_data,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_data,
  output logic               rf_wr,
  output logic [ADDR_W-1:0]  rf_wr_addr,
  output logic [DATA_W-1:0]  rf_wr_data,
  input  logic               sb_set,
  input  logic [ADDR_W-1:0]  sb_set_addr,
  output logic [NUM_GPR-1:0] sb_busy,
  output logic               sb_err
);

  localparam logic [ADDR_W:0] NUM_GPR_L = NUM_GPR[ADDR_W:0];

  logic              gnt_alu_p0, gnt_mem_p0;
  logic [ADDR_W-1:0] win_addr_p0;
  logic [DATA_W-1:0] win_data_p0;
  logic              win_wr_p0;

  logic              vld_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [DATA_W-1:0] wr_data_p1;

  zmips_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (alu_valid),
    .req1  (mem_valid),
    .gnt0  (gnt_alu_p0),
    .gnt1  (gnt_mem_p0)
  );

  assign alu_ready = gnt_alu_p0;
  assign mem_ready = gnt_mem_p0;

  // Stage p0: select the winner and drop writes aimed at the PC aliases.
  always_comb begin
    win_addr_p0 = gnt_mem_p0 ? mem_addr : alu_addr;
    win_data_p0 = gnt_mem_p0 ? mem_data : alu_data;
    win_wr_p0   = (gnt_alu_p0 || gnt_mem_p0) && ({1'b0, win_addr_p0} < NUM_GPR_L);
  end

`ifdef ZMIPS_RF_SCOREBOARD_EN
  wb_src_t            src_p1;
  logic [NUM_GPR-1:0] busy_q, busy_nxt;
  logic               err_q;
  logic               alu_hit_busy;
`endif

  // Stage p1: the registered regfile write. Address and data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
`ifdef ZMIPS_RF_SCOREBOARD_EN
      src_p1     <= ALU;
`endif
    end else begin
      vld_p1 <= win_wr_p0;
      if (win_wr_p0) begin
        wr_addr_p1 <= win_addr_p0;
        wr_data_p1 <= win_data_p0;
`ifdef ZMIPS_RF_SCOREBOARD_EN
        src_p1     <= gnt_mem_p0 ? MEM : ALU;
`endif
      end
    end
  end

  assign rf_wr      = vld_p1;
  assign rf_wr_addr = wr_addr_p1;
  assign rf_wr_data = wr_data_p1;

`ifdef ZMIPS_RF_SCOREBOARD_EN
  // A load commit clears its bit, and a same-edge set overrides the clear.
  // Addresses at or above NUM_GPR never match a bit.
  always_comb begin
    busy_nxt     = busy_q;
    alu_hit_busy = 1'b0;
    for (int i = 0; i < NUM_GPR; i++) begin
      if (vld_p1 && (src_p1 == MEM) && (wr_addr_p1 == ADDR_W'(i))) busy_nxt[i] = 1'b0;
      if (sb_set && (sb_set_addr == ADDR_W'(i)))                   busy_nxt[i] = 1'b1;
      if (alu_addr == ADDR_W'(i)) alu_hit_busy = busy_q[i];
    end
  end

  // Scoreboard state. The WAW error is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      if (gnt_alu_p0 && alu_hit_busy) err_q <= 1'b1;
    end
  end

  assign sb_busy = busy_q;
  assign sb_err  = err_q;
`else
  logic unused_sb;
  assign unused_sb = ^{sb_set, sb_set_addr};
  assign sb_busy   = '0;
  assign sb_err    = 1'b0;
`endif

endmodule

// File: tb/tb_zmips_rf_wr_arbiter.sv
// Bench for zmips_rf_wr_arbiter. It applies a table of arbitration vectors,
// then hand-written scoreboard, WAW-error and mid-stream reset sequences.
// Scoreboard expectations follow whether ZMIPS_RF_SCOREBOARD_EN is defined.
module tb_zmips_rf_wr_arbiter;

`ifdef ZMIPS_RF_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_addr = '0, mem_addr = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        rf_wr;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_set_addr = '0;
  logic [29:0] sb_busy;
  logic        sb_err;

  zmips_rf_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_GPR(30)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_wr(rf_wr), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr), .sb_busy(sb_busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av; logic [4:0] aa; logic [31:0] ad;
    logic        mv; logic [4:0] ma; logic [31:0] md;
    logic        ea; logic       em;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [4:0]  hold_addr = '0;
  logic [31:0] hold_data = '0;
  logic        rr_last = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check readies at the negedge, queue the expected write,
  // then compare the registered write just after the posedge.
  task automatic cyc(input logic ea, input logic em);
    wr_t e, g;
    @(negedge clk);
    chk("alu_ready", 64'(alu_ready), 64'(ea));
    chk("mem_ready", 64'(mem_ready), 64'(em));
    e.wr = 1'b0; e.addr = hold_addr; e.data = hold_data;
    if ((ea && alu_valid && alu_addr < 5'd30) || (em && mem_valid && mem_addr < 5'd30)) begin
      e.wr   = 1'b1;
      e.addr = (ea && alu_valid) ? alu_addr : mem_addr;
      e.data = (ea && alu_valid) ? alu_data : mem_data;
      hold_addr = e.addr;
      hold_data = e.data;
    end
    if (ea && alu_valid) rr_last = 1'b0;
    else if (em && mem_valid) rr_last = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      g = exp_q.pop_front();
      chk("rf_wr", 64'(rf_wr), 64'(g.wr));
      chk("rf_wr_addr", 64'(rf_wr_addr), 64'(g.addr));
      chk("rf_wr_data", 64'(rf_wr_data), 64'(g.data));
    end
  endtask

  // Round-robin expectation for the hand-written sequences.
  task automatic cyc_rr();
    logic ea, em;
    ea = alu_valid && (!mem_valid || rr_last);
    em = mem_valid && (!alu_valid || !rr_last);
    cyc(ea, em);
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    tbl[0]  = '{1'b1, 5'd5,  32'h11,   1'b1, 5'd6,  32'h22,   1'b1, 1'b0};
    tbl[1]  = '{1'b1, 5'd8,  32'h33,   1'b1, 5'd6,  32'h22,   1'b0, 1'b1};
    tbl[2]  = '{1'b1, 5'd8,  32'h33,   1'b1, 5'd10, 32'h44,   1'b1, 1'b0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd10, 32'h44,   1'b0, 1'b1};
    tbl[4]  = '{1'b1, 5'd30, 32'hFFFF, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd31, 32'hABCD, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 5'd1,  32'h9,    1'b0, 5'd2,  32'h9,    1'b0, 1'b0};
    tbl[7]  = '{1'b1, 5'd1,  32'h1,    1'b0, 5'd0,  32'h0,    1'b1, 1'b0};
    tbl[8]  = '{1'b1, 5'd2,  32'h2,    1'b0, 5'd0,  32'h0,    1'b1, 1'b0};
    tbl[9]  = '{1'b1, 5'd3,  32'h3,    1'b1, 5'd4,  32'h4,    1'b0, 1'b1};
    tbl[10] = '{1'b1, 5'd3,  32'h3,    1'b1, 5'd29, 32'h29,   1'b1, 1'b0};
    tbl[11] = '{1'b1, 5'd0,  32'hA,    1'b1, 5'd29, 32'h29,   1'b0, 1'b1};

    // Reset state
    #12;
    chk("rst_rf_wr", 64'(rf_wr), 64'd0);
    chk("rst_rf_wr_addr", 64'(rf_wr_addr), 64'd0);
    chk("rst_sb_busy", 64'(sb_busy), 64'd0);
    chk("rst_sb_err", 64'(sb_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table-driven arbitration and write path
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md);
      cyc(tbl[i].ea, tbl[i].em);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cyc_rr();

    // Load scoreboard set, then clear after the commit edge
    sb_set = 1'b1; sb_set_addr = 5'd7;
    cyc_rr();
    chk("busy7_set", 64'(sb_busy[7]), 64'(SB_EN));
    sb_set = 1'b1; sb_set_addr = 5'd30;
    cyc_rr();
    chk("busy_pc_set_ignored", 64'(sb_busy), 64'(SB_EN ? 30'h80 : 30'h0));
    sb_set = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEAD);
    cyc_rr();
    chk("busy7_during_commit", 64'(sb_busy[7]), 64'(SB_EN));
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cyc_rr();
    chk("busy7_cleared", 64'(sb_busy[7]), 64'd0);

    // Set and clear of r7 at the same edge: set wins
    sb_set = 1'b1; sb_set_addr = 5'd7;
    cyc_rr();
    sb_set = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hBEEF);
    cyc_rr();
    sb_set = 1'b1; sb_set_addr = 5'd7;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cyc_rr();
    sb_set = 1'b0;
    chk("busy7_collision", 64'(sb_busy[7]), 64'(SB_EN));
    cyc_rr();
    chk("busy7_after_collision", 64'(sb_busy[7]), 64'(SB_EN));

    // WAW error: ALU write to a busy register still proceeds
    sb_set = 1'b1; sb_set_addr = 5'd9;
    cyc_rr();
    sb_set = 1'b0;
    chk("err_before_waw", 64'(sb_err), 64'd0);
    drive(1'b1, 5'd9, 32'h5, 1'b0, 5'd0, 32'h0);
    cyc_rr();
    chk("err_waw", 64'(sb_err), 64'(SB_EN));
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) cyc_rr();
    chk("err_sticky", 64'(sb_err), 64'(SB_EN));

    // Mid-stream reset with back-to-back alternating writes
    drive(1'b1, 5'd11, 32'h111, 1'b1, 5'd12, 32'h222);
    for (int i = 0; i < 3; i++) cyc_rr();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rf_wr", 64'(rf_wr), 64'd0);
    chk("midrst_rf_wr_addr", 64'(rf_wr_addr), 64'd0);
    chk("midrst_rf_wr_data", 64'(rf_wr_data), 64'd0);
    chk("midrst_sb_busy", 64'(sb_busy), 64'd0);
    chk("midrst_sb_err", 64'(sb_err), 64'd0);
    exp_q.delete();
    hold_addr = '0; hold_data = '0; rr_last = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cyc_rr();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
